// File: rtl/core_abuf_pkg.sv
// Shared sizing helpers and pointer arithmetic for the multi-channel activation buffer.
package core_abuf_pkg;

  // Widest pointer ptr_dist handles. This covers depths up to 2^15 entries.
  localparam int PTR_W_MAX = 16;

  function automatic int calc_r(input int gbus_w, input int abuf_w);
    return abuf_w / gbus_w;
  endfunction

  function automatic int calc_addr(input int depth);
    return $clog2(depth);
  endfunction

  function automatic int calc_idw(input int nrd);
    return (nrd > 1) ? $clog2(nrd) : 1;
  endfunction

  // Derived sizes for the default configuration (32-bit link, 128-bit entries, 16 deep, 2 readers).
  localparam int R    = calc_r(32, 128);
  localparam int ADDR = calc_addr(16);
  localparam int IDW  = calc_idw(2);

  // Wrap-aware distance a - b for pointers that are pw bits wide, including the wrap bit.
  function automatic logic [PTR_W_MAX-1:0] ptr_dist(input logic [PTR_W_MAX-1:0] a,
                                                    input logic [PTR_W_MAX-1:0] b,
                                                    input int                   pw);
    logic [PTR_W_MAX-1:0] mask;
    mask = (PTR_W_MAX'(1) << pw) - PTR_W_MAX'(1);
    return (a - b) & mask;
  endfunction

endpackage

// File: rtl/core_abuf_pack.sv
// Link register plus GBUS->ABUF serial-to-parallel packer.
// The first registered word lands in the LSBs. ent_wen pulses on the beat that completes an entry.
module core_abuf_pack
  import core_abuf_pkg::*;
#(
  parameter int GBUS_DATA = 32,
  parameter int ABUF_DATA = 128
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 flush,
  input  logic [GBUS_DATA-1:0] clink_wdata,
  input  logic                 clink_wen,
  output logic [GBUS_DATA-1:0] clink_rdata,
  output logic                 clink_rvalid,
  output logic [ABUF_DATA-1:0] ent_data,
  output logic                 ent_wen
);

  localparam int BEATS = calc_r(GBUS_DATA, ABUF_DATA);
  localparam int SW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  logic [GBUS_DATA-1:0] link_data_q, link_data_d;
  logic                 link_vld_q, link_vld_d;
  logic [SW-1:0]        slot_q, slot_d;
  logic [ABUF_DATA-1:0] acc_q, acc_d;

  // Link stage. Flush leaves it alone. The data holds while no word arrives.
  always_comb begin
    link_vld_d  = clink_wen;
    link_data_d = clink_wen ? clink_wdata : link_data_q;
  end

  // Packer: drop each registered word into its slot, and fire the write strobe on the last slot.
  always_comb begin
    slot_d  = slot_q;
    acc_d   = acc_q;
    ent_wen = 1'b0;
    if (flush) begin
      slot_d = '0;
    end else if (link_vld_q) begin
      for (int k = 0; k < BEATS; k++)
        if (slot_q == SW'(k)) acc_d[k*GBUS_DATA +: GBUS_DATA] = link_data_q;
      if (slot_q == SW'(BEATS-1)) begin
        ent_wen = 1'b1;
        slot_d  = '0;
      end else begin
        slot_d = slot_q + SW'(1);
      end
    end
  end

  // Link and packer state registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      link_data_q <= '0;
      link_vld_q  <= 1'b0;
      slot_q      <= '0;
      acc_q       <= '0;
    end else begin
      link_data_q <= link_data_d;
      link_vld_q  <= link_vld_d;
      slot_q      <= slot_d;
      acc_q       <= acc_d;
    end
  end

  assign clink_rdata  = link_data_q;
  assign clink_rvalid = link_vld_q;
  assign ent_data     = acc_d;

endmodule

// File: rtl/core_abuf_mc.sv
// Multi-channel activation buffer: a circular entry store with NUM_RD re-readable cursors.
// The cursors share one registered read port through fixed-priority arbitration.
// Entries are freed only by an explicit release. "release" is a reserved word, so that port is abuf_release.
module core_abuf_mc
  import core_abuf_pkg::*;
#(
  parameter int GBUS_DATA   = 32,
  parameter int ABUF_DATA   = 128,
  parameter int ABUF_DEPTH  = 16,
  parameter int NUM_RD      = 2,
  parameter int ALERT_DEPTH = 3
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          flush,
  input  logic [GBUS_DATA-1:0]          clink_wdata,
  input  logic                          clink_wen,
  output logic [GBUS_DATA-1:0]          clink_rdata,
  output logic                          clink_rvalid,
  input  logic [NUM_RD-1:0]             rd_ren,
  input  logic [NUM_RD-1:0]             rd_rewind,
  output logic [NUM_RD-1:0]             rd_gnt,
  output logic [NUM_RD-1:0]             rd_empty,
  output logic [ABUF_DATA-1:0]          rdata,
  output logic                          rvalid,
  output logic [calc_idw(NUM_RD)-1:0]   rid,
  input  logic                          abuf_release,
  output logic                          abuf_empty,
  output logic                          abuf_full,
  output logic                          abuf_almost_full,
  output logic                          err_ovf,
  output logic                          err_rel
);

  localparam int AW = calc_addr(ABUF_DEPTH);
  localparam int IW = calc_idw(NUM_RD);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] FULL_LVL = PW'(ABUF_DEPTH);
  localparam logic [PW-1:0] AF_LVL   = PW'(ABUF_DEPTH - ALERT_DEPTH);

  logic [ABUF_DATA-1:0]         ent_data;
  logic                         ent_wen;

  logic [PW-1:0]                wptr_q, wptr_d, head_q, head_d;
  logic [NUM_RD-1:0][PW-1:0]    cur_q, cur_d;
  logic                         err_ovf_q, err_ovf_d, err_rel_q, err_rel_d;
  logic                         rvalid_q, rvalid_d;
  logic [IW-1:0]                rid_q, rid_d;
  logic [ABUF_DATA-1:0]         rdata_q, rdata_d;
  logic [ABUF_DATA-1:0]         mem_q [ABUF_DEPTH];
  logic [ABUF_DATA-1:0]         mem_d [ABUF_DEPTH];

  logic [PW-1:0]                count;
  logic                         full, do_wr, rel_ok, cur_at_head, found;
  logic [NUM_RD-1:0]            gnt;
  logic [IW-1:0]                gid;

  core_abuf_pack #(
    .GBUS_DATA (GBUS_DATA),
    .ABUF_DATA (ABUF_DATA)
  ) u_pack (
    .clk          (clk),
    .rstn         (rstn),
    .flush        (flush),
    .clink_wdata  (clink_wdata),
    .clink_wen    (clink_wen),
    .clink_rdata  (clink_rdata),
    .clink_rvalid (clink_rvalid),
    .ent_data     (ent_data),
    .ent_wen      (ent_wen)
  );

  assign count = PW'(ptr_dist(PTR_W_MAX'(wptr_q), PTR_W_MAX'(head_q), PW));
  assign full  = (count == FULL_LVL);
  // A completed entry is stored only when there is room. Otherwise it is dropped and err_ovf flags it.
  assign do_wr = ent_wen & ~full;

  // Per-cursor empty flags, and whether any cursor still sits on the oldest entry
  always_comb begin
    cur_at_head = 1'b0;
    rd_empty    = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rd_empty[i] = (cur_q[i] == wptr_q);
      if (cur_q[i] == head_q) cur_at_head = 1'b1;
    end
  end

  // Fixed-priority grant: the lowest cursor with data that is not rewinding this cycle
  always_comb begin
    gnt   = '0;
    gid   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (!found && !flush && rd_ren[i] && !rd_empty[i] && !rd_rewind[i]) begin
        gnt[i] = 1'b1;
        gid    = IW'(i);
        found  = 1'b1;
      end
    end
  end

  // Releasing while a cursor still points at head would free data that cursor has not read yet
  assign rel_ok = abuf_release & (count != '0) & ~cur_at_head;

  // Pointer, sticky-error and read-port next state. Flush wins over everything.
  always_comb begin
    wptr_d    = wptr_q;
    head_d    = head_q;
    cur_d     = cur_q;
    err_ovf_d = err_ovf_q;
    err_rel_d = err_rel_q;
    rvalid_d  = 1'b0;
    rid_d     = rid_q;
    rdata_d   = rdata_q;
    if (flush) begin
      wptr_d    = '0;
      head_d    = '0;
      cur_d     = '0;
      err_ovf_d = 1'b0;
      err_rel_d = 1'b0;
    end else begin
      if (do_wr)                    wptr_d    = wptr_q + PW'(1);
      if (ent_wen && full)          err_ovf_d = 1'b1;
      if (rel_ok)                   head_d    = head_q + PW'(1);
      if (abuf_release && !rel_ok)  err_rel_d = 1'b1;
      // A rewind picks up the post-release head, so the cursor never trails the freed entry
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_rewind[i])  cur_d[i] = head_d;
        else if (gnt[i])   cur_d[i] = cur_q[i] + PW'(1);
      end
      if (found) begin
        rvalid_d = 1'b1;
        rid_d    = gid;
        rdata_d  = mem_q[cur_q[gid][AW-1:0]];
      end
    end
  end

  // Storage write: one completed entry per cycle, at wptr
  always_comb begin
    mem_d = mem_q;
    if (do_wr) mem_d[wptr_q[AW-1:0]] = ent_data;
  end

  // Entry storage has no reset. Pointers decide what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  // Control and read-port registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr_q    <= '0;
      head_q    <= '0;
      cur_q     <= '0;
      err_ovf_q <= 1'b0;
      err_rel_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
    end else begin
      wptr_q    <= wptr_d;
      head_q    <= head_d;
      cur_q     <= cur_d;
      err_ovf_q <= err_ovf_d;
      err_rel_q <= err_rel_d;
      rvalid_q  <= rvalid_d;
      rid_q     <= rid_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rd_gnt           = gnt;
  assign rdata            = rdata_q;
  assign rvalid           = rvalid_q;
  assign rid              = rid_q;
  assign abuf_empty       = (count == '0);
  assign abuf_full        = full;
  assign abuf_almost_full = (count >= AF_LVL);
  assign err_ovf          = err_ovf_q;
  assign err_rel          = err_rel_q;

endmodule

// File: tb/tb_core_abuf_mc.sv
// Bench for core_abuf_mc. The config is an 8-bit link, 32-bit entries, 8 entries deep and 2 cursors.
// A queue/counter model of the buffer is compared against the DUT every cycle.
// Directed literal checks pin the model itself.
module tb_core_abuf_mc;

  localparam int GB = 8;
  localparam int AB = 32;
  localparam int DP = 8;
  localparam int NR = 2;
  localparam int AL = 2;
  localparam int R  = AB / GB;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          flush = 1'b0;
  logic [GB-1:0] clink_wdata = '0;
  logic          clink_wen = 1'b0;
  logic [GB-1:0] clink_rdata;
  logic          clink_rvalid;
  logic [NR-1:0] rd_ren = '0;
  logic [NR-1:0] rd_rewind = '0;
  logic [NR-1:0] rd_gnt, rd_empty;
  logic [AB-1:0] rdata;
  logic          rvalid;
  logic [0:0]    rid;
  logic          abuf_release = 1'b0;
  logic          abuf_empty, abuf_full, abuf_almost_full, err_ovf, err_rel;

  int errors = 0;
  int checks = 0;

  core_abuf_mc #(
    .GBUS_DATA (GB), .ABUF_DATA (AB), .ABUF_DEPTH (DP), .NUM_RD (NR), .ALERT_DEPTH (AL)
  ) dut (
    .clk (clk), .rstn (rstn), .flush (flush),
    .clink_wdata (clink_wdata), .clink_wen (clink_wen),
    .clink_rdata (clink_rdata), .clink_rvalid (clink_rvalid),
    .rd_ren (rd_ren), .rd_rewind (rd_rewind), .rd_gnt (rd_gnt), .rd_empty (rd_empty),
    .rdata (rdata), .rvalid (rvalid), .rid (rid),
    .abuf_release (abuf_release),
    .abuf_empty (abuf_empty), .abuf_full (abuf_full), .abuf_almost_full (abuf_almost_full),
    .err_ovf (err_ovf), .err_rel (err_rel)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Positions are unbounded entry numbers. elog maps an entry number to its data.
  int            m_wptr, m_head;
  int            m_cur [NR];
  logic [AB-1:0] elog [int];
  logic [GB-1:0] pk_q [$];
  logic          m_lvld, m_ovf, m_rel, m_rvalid;
  logic [GB-1:0] m_ldata;
  logic [AB-1:0] m_rdata;
  int            m_rid;

  function automatic int exp_gnt();
    if (flush) return -1;
    for (int i = 0; i < NR; i++)
      if (rd_ren[i] && !rd_rewind[i] && m_cur[i] != m_wptr) return i;
    return -1;
  endfunction

  task automatic model_clear();
    m_wptr = 0; m_head = 0;
    for (int i = 0; i < NR; i++) m_cur[i] = 0;
    elog.delete(); pk_q.delete();
    m_ovf = 1'b0; m_rel = 1'b0; m_rvalid = 1'b0;
  endtask

  task automatic model_reset();
    model_clear();
    m_lvld = 1'b0; m_ldata = '0; m_rdata = '0; m_rid = 0;
  endtask

  task automatic model_step();
    int            g, cnt;
    logic          done, ok, at_head;
    logic [AB-1:0] e;
    if (flush) begin
      model_clear();
    end else begin
      g    = exp_gnt();
      cnt  = m_wptr - m_head;
      done = 1'b0;
      e    = '0;
      if (m_lvld) begin
        pk_q.push_back(m_ldata);
        if (pk_q.size() == R) begin
          foreach (pk_q[k]) e[k*GB +: GB] = pk_q[k];
          pk_q.delete();
          done = 1'b1;
        end
      end
      at_head = 1'b0;
      for (int i = 0; i < NR; i++) if (m_cur[i] == m_head) at_head = 1'b1;
      ok = abuf_release && cnt > 0 && !at_head;
      m_rvalid = (g >= 0);
      if (g >= 0) begin
        m_rdata = elog[m_cur[g]];
        m_rid   = g;
        m_cur[g]++;
      end
      if (done) begin
        if (cnt < DP) begin elog[m_wptr] = e; m_wptr++; end
        else m_ovf = 1'b1;
      end
      if (ok) m_head++;
      else if (abuf_release) m_rel = 1'b1;
      for (int i = 0; i < NR; i++) if (rd_rewind[i]) m_cur[i] = m_head;
    end
    m_lvld = clink_wen;
    if (clink_wen) m_ldata = clink_wdata;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) model_reset();
      else       model_step();
    end
  end

  // Every-cycle comparison against the model, on the falling edge
  initial begin
    int g, cnt;
    forever begin
      @(negedge clk);
      g   = exp_gnt();
      cnt = m_wptr - m_head;
      chk("cmp_clink_rvalid", 32'(clink_rvalid), 32'(m_lvld));
      chk("cmp_clink_rdata", 32'(clink_rdata), 32'(m_ldata));
      for (int i = 0; i < NR; i++) chk("cmp_rd_empty", 32'(rd_empty[i]), 32'(m_cur[i] == m_wptr));
      chk("cmp_rd_gnt", 32'(rd_gnt), (g >= 0) ? (32'd1 << g) : 32'd0);
      chk("cmp_abuf_empty", 32'(abuf_empty), 32'(cnt == 0));
      chk("cmp_abuf_full", 32'(abuf_full), 32'(cnt == DP));
      chk("cmp_almost_full", 32'(abuf_almost_full), 32'(cnt >= DP - AL));
      chk("cmp_err_ovf", 32'(err_ovf), 32'(m_ovf));
      chk("cmp_err_rel", 32'(err_rel), 32'(m_rel));
      chk("cmp_rvalid", 32'(rvalid), 32'(m_rvalid));
      if (m_rvalid) begin
        chk("cmp_rdata", rdata, m_rdata);
        chk("cmp_rid", 32'(rid), 32'(m_rid));
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic put_entry(input logic [AB-1:0] e);
    for (int k = 0; k < R; k++) begin
      clink_wen   = 1'b1;
      clink_wdata = e[k*GB +: GB];
      tick();
    end
    clink_wen = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1; tick(); flush = 1'b0;
  endtask

  initial begin
    #1 rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;

    // reset state
    chk("rst_abuf_empty", 32'(abuf_empty), 32'd1);
    chk("rst_rd_empty", 32'(rd_empty), 32'h3);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_full", 32'(abuf_full), 32'd0);

    // pack and read
    put_entry(32'h44332211);
    chk("pack_empty_t1", 32'(rd_empty[0]), 32'd1);
    tick();
    chk("pack_empty_t2", 32'(rd_empty[0]), 32'd0);
    rd_ren = 2'b01; #1 chk("pack_gnt", 32'(rd_gnt), 32'h1);
    tick(); rd_ren = 2'b00;
    chk("pack_rvalid", 32'(rvalid), 32'd1);
    chk("pack_rdata", rdata, 32'h44332211);
    chk("pack_rid", 32'(rid), 32'd0);
    tick();
    chk("pack_rvalid_1cyc", 32'(rvalid), 32'd0);

    // full, almost-full and overflow
    do_flush();
    for (int n = 0; n < 5; n++) put_entry(32'hA0000000 | 32'(n));
    tick();
    chk("af_at5", 32'(abuf_almost_full), 32'd0);
    put_entry(32'hA0000005); tick();
    chk("af_at6", 32'(abuf_almost_full), 32'd1);
    chk("full_at6", 32'(abuf_full), 32'd0);
    put_entry(32'hA0000006); put_entry(32'hA0000007); tick();
    chk("full_at8", 32'(abuf_full), 32'd1);
    chk("ovf_at8", 32'(err_ovf), 32'd0);
    put_entry(32'hA0000008); tick();
    chk("ovf_set", 32'(err_ovf), 32'd1);
    chk("full_after_ovf", 32'(abuf_full), 32'd1);

    // reuse via rewind, independent cursors
    do_flush();
    chk("flush_ovf_clr", 32'(err_ovf), 32'd0);
    put_entry(32'h0A0B0C0D); put_entry(32'h1A1B1C1D); put_entry(32'h2A2B2C2D); tick();
    rd_ren = 2'b01;
    tick(); chk("reuse_r0", rdata, 32'h0A0B0C0D);
    tick(); chk("reuse_r1", rdata, 32'h1A1B1C1D);
    tick(); chk("reuse_r2", rdata, 32'h2A2B2C2D);
    rd_ren = 2'b00;
    chk("reuse_c0_empty", 32'(rd_empty[0]), 32'd1);
    rd_rewind = 2'b01; tick(); rd_rewind = 2'b00;
    rd_ren = 2'b01; tick(); rd_ren = 2'b00;
    chk("rewind_rdata", rdata, 32'h0A0B0C0D);
    rd_ren = 2'b10; tick(); rd_ren = 2'b00;
    chk("c1_rdata", rdata, 32'h0A0B0C0D);
    chk("c1_rid", 32'(rid), 32'd1);

    // arbitration: cur0 = cur1 = 1, wptr = 3
    rd_ren = 2'b11; #1 chk("arb_gnt0", 32'(rd_gnt), 32'h1);
    tick(); chk("arb_rid_a", 32'(rid), 32'd0); chk("arb_d_a", rdata, 32'h1A1B1C1D);
    tick(); chk("arb_rid_b", 32'(rid), 32'd0); chk("arb_d_b", rdata, 32'h2A2B2C2D);
    #1 chk("arb_gnt1", 32'(rd_gnt), 32'h2);
    tick(); chk("arb_rid_c", 32'(rid), 32'd1); chk("arb_d_c", rdata, 32'h1A1B1C1D);
    tick(); chk("arb_rid_d", 32'(rid), 32'd1); chk("arb_d_d", rdata, 32'h2A2B2C2D);
    rd_ren = 2'b00;

    // release rules
    rd_rewind = 2'b10; tick(); rd_rewind = 2'b00;
    abuf_release = 1'b1; tick(); abuf_release = 1'b0;
    chk("rel_illegal", 32'(err_rel), 32'd1);
    rd_ren = 2'b10; tick(); rd_ren = 2'b00;
    put_entry(32'h3A3B3C3D);
    abuf_release = 1'b1; tick(); abuf_release = 1'b0;
    tick();
    rd_rewind = 2'b10; tick(); rd_rewind = 2'b00;
    rd_ren = 2'b10; tick(); rd_ren = 2'b00;
    chk("rel_head1", rdata, 32'h1A1B1C1D);
    abuf_release = 1'b1; rd_rewind = 2'b10; tick();
    abuf_release = 1'b0; rd_rewind = 2'b00;
    rd_ren = 2'b10; tick(); rd_ren = 2'b00;
    chk("rel_rewind_head2", rdata, 32'h2A2B2C2D);

    // flush mid-pack
    do_flush();
    chk("flush_rel_clr", 32'(err_rel), 32'd0);
    clink_wen = 1'b1; clink_wdata = 8'h55; tick();
    clink_wdata = 8'h66; tick();
    clink_wen = 1'b0; tick();
    do_flush();
    put_entry(32'h99887766); tick();
    rd_ren = 2'b01; tick(); rd_ren = 2'b00;
    chk("flush_fresh", rdata, 32'h99887766);

    // async reset during a pending read
    put_entry(32'hDEADBEEF); tick();
    rd_ren = 2'b01; #1 chk("rst_rd_gnt", 32'(rd_gnt), 32'h1);
    #2 rstn = 1'b0;
    @(posedge clk); #1; rd_ren = 2'b00;
    chk("rstrd_rvalid", 32'(rvalid), 32'd0);
    chk("rstrd_rd_empty", 32'(rd_empty), 32'h3);
    chk("rstrd_abuf_empty", 32'(abuf_empty), 32'd1);
    tick(); rstn = 1'b1; tick();

    // async reset mid-pack discards partial words
    clink_wen = 1'b1; clink_wdata = 8'h77; tick();
    clink_wdata = 8'h78; tick();
    clink_wen = 1'b0;
    rstn = 1'b0; tick(); rstn = 1'b1; tick();
    put_entry(32'h0F0E0D0C); tick();
    rd_ren = 2'b01; tick(); rd_ren = 2'b00;
    chk("rstpk_fresh", rdata, 32'h0F0E0D0C);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
